flop_fifo_wm: RTL
=================

FLOP_FIFO_WM -- requirements
Module: flop_fifo_wm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (>=2, any integer, not only powers of two).
REQ-003 SHALL have localparam CNT_W = $clog2(DEPTH+1), the occupancy counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port clr  in  1  synchronous flush, active-high.
REQ-007 SHALL have port cfg_watermark  in  CNT_W  occupancy threshold.
REQ-008 SHALL have port push  in  1  write request.
REQ-009 SHALL have port push_data  in  WIDTH  write data.
REQ-010 SHALL have port push_rdy  out  1  space available (= !full).
REQ-011 SHALL have port pop  in  1  read request.
REQ-012 SHALL have port pop_data  out  WIDTH  head entry, first-word-fall-through.
REQ-013 SHALL have port data_valid  out  1  head entry valid (= !empty).
REQ-014 SHALL have port count  out  CNT_W  current occupancy.
REQ-015 SHALL have port half_full, watermark, full  out  1 each  status flags.
REQ-016 SHALL have port err_clr  in  1  clears sticky errors; ports ovf_err, unf_err  out  1 each.
REQ-017 SHALL have port peak  out  CNT_W  highest occupancy since reset/clr.

Function
REQ-018 SHALL accept a push when push && push_rdy; SHALL accept a pop when pop && data_valid.
REQ-019 SHALL store entries in flops; a circular buffer with rd/wr pointers wrapping at DEPTH-1 -> 0 (no power-of-two assumption).
REQ-020 SHALL present the oldest entry on pop_data combinationally from storage; a pushed word SHALL be visible on pop_data with data_valid=1 the cycle after acceptance (1-cycle latency).
REQ-021 SHALL update count: +1 on push-only, -1 on pop-only, unchanged on simultaneous accepted push+pop or neither.
REQ-022 SHALL allow simultaneous accepted push and pop at any non-empty, non-full occupancy; when full, push_rdy=0 regardless of pop (no bypass); when empty, pop is not accepted and the push completes normally.
REQ-023 SHALL drive full = (count == DEPTH), data_valid = (count != 0), half_full = (count >= DEPTH/2, integer division), watermark = (count >= cfg_watermark); all decoded from registered count.
REQ-024 SHALL treat cfg_watermark=0 as watermark always 1 and cfg_watermark>DEPTH as watermark always 0.
REQ-025 SHALL set ovf_err on a cycle with push && !push_rdy; SHALL set unf_err on pop && !data_valid; both sticky until err_clr or rst; a set event in the same cycle as err_clr SHALL win (flag stays 1).
REQ-026 SHALL register peak = max(peak, next count) each cycle.
REQ-027 SHALL, on clr, next cycle set count=0, pointers=0, peak=0, and ignore push/pop that cycle (no error flags set); storage contents need not be cleared; ovf_err/unf_err SHALL be unaffected by clr.
REQ-028 SHALL not reset data storage flops (data-path only; validity derived from count).

Reset
REQ-029 SHALL, while rst=1 (asynchronously, including mid-operation), force count=0, pointers=0, peak=0, ovf_err=0, unf_err=0; thus data_valid=0, push_rdy=1, full=0, half_full=0, watermark=(cfg_watermark==0).
REQ-030 SHALL accept the first push on the first posedge after rst deasserts.
REQ-031 pop_data value SHALL be don't-care whenever data_valid=0.

Verification (DEPTH=4, WIDTH=8 unless noted)
REQ-032 Fill/drain: push 0x11,0x22,0x33,0x44 back-to-back -> count 1..4, full=1, push_rdy=0 after 4th; pop 4x -> pop_data 0x11,0x22,0x33,0x44 in order, data_valid=0 after.
REQ-033 Wrap: push 3, pop 2, push 3 -> count=4, pops return correct order across pointer wrap; DEPTH=5 rerun passes identically.
REQ-034 Simultaneous: count=2, push+pop held 6 cycles -> count stays 2, FIFO order preserved; at count=4 push+pop -> only pop accepted, count=3, ovf_err=1.
REQ-035 Errors: pop when empty -> unf_err=1, count stays 0; err_clr pulse -> 0; err_clr with same-cycle overflow -> ovf_err stays 1.
REQ-036 Flags: cfg_watermark=3 -> watermark rises on 3rd accepted push; half_full rises on 2nd; peak=4 after fill, stays 4 after drain; clr -> peak=0, count=0.
REQ-037 Async reset mid-stream: rst asserted between clock edges at count=3 -> count=0, data_valid=0, push_rdy=1 immediately, before next posedge.

Source files
------------

// File: rtl/flop_fifo_wm.sv
// Flop-based FIFO with first-word-fall-through output, occupancy and watermark
// status, sticky overflow/underflow errors and a peak-occupancy tracker.
module flop_fifo_wm #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] cfg_watermark,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_rdy,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             data_valid,
  output logic [CNT_W-1:0] count,
  output logic             half_full,
  output logic             watermark,
  output logic             full,
  input  logic             err_clr,
  output logic             ovf_err,
  output logic             unf_err,
  output logic [CNT_W-1:0] peak
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] peak_q, peak_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic full_s, data_valid_s;
  logic push_acc_s, pop_acc_s, ovf_set_s, unf_set_s;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_s       = (count_q == CNT_W'(DEPTH));
  assign data_valid_s = (count_q != '0);

  // A flush cycle swallows push/pop entirely, including their error events.
  assign push_acc_s = push && !full_s && !clr;
  assign pop_acc_s  = pop && data_valid_s && !clr;
  assign ovf_set_s  = push && full_s && !clr;
  assign unf_set_s  = pop && !data_valid_s && !clr;

  // Next-state for pointers, occupancy, peak and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_acc_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_acc_s, pop_acc_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (clr) begin
      peak_d = '0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end else begin
      peak_d = peak_q;
    end

    // A set event outranks a same-cycle clear.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (unf_set_s) begin
      unf_d = 1'b1;
    end else if (err_clr) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Data storage is not reset; validity comes from the occupancy count.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data   = mem_q[rd_ptr_q];
  assign data_valid = data_valid_s;
  assign push_rdy   = !full_s;
  assign full       = full_s;
  assign half_full  = (count_q >= CNT_W'(DEPTH / 2));
  assign watermark  = (count_q >= cfg_watermark);
  assign count      = count_q;
  assign peak       = peak_q;
  assign ovf_err    = ovf_q;
  assign unf_err    = unf_q;

endmodule
